goalie_move_ctrl: RTL
=====================

GOALIE_MOVE_CTRL -- requirements
Module: goalie_move_ctrl

Interface
REQ-001 Parameter STEPS_PER_SLOT, default 200: stepper steps between adjacent goal slots.
REQ-002 Parameter SETTLE_CYCLES, default 1000: clk cycles held in SETTLE after a move.
REQ-003 Parameter TIMEOUT_CYCLES, default 100000000: move watchdog limit; used only with GOALIE_TIMEOUT_EN.
REQ-004 clk  input  1  system clock (100 MHz); single clock domain.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 auto_valid  input  1  one-cycle strobe from phototransistor scanner: ball detected.
REQ-007 auto_slot  input  3  slot index (0-7) of darkest phototransistor; sampled with auto_valid.
REQ-008 cpu_valid  input  1  one-cycle strobe: CPU wrote a target through the IO register.
REQ-009 cpu_target  input  32  absolute step target from CPU; sampled with cpu_valid.
REQ-010 step_valid  output  1  command valid to stepper driver.
REQ-011 step_ready  input  1  stepper accepts command when step_valid && step_ready.
REQ-012 step_target  output  32  absolute step target to stepper driver.
REQ-013 step_busy  input  1  stepper is moving.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 cur_pos  output  32  last target accepted by stepper (committed position).
REQ-016 status  output  32  CPU-readable: [0] busy, [1] cpu_pending, [2] auto_pending, [3] fault, [6:4] last auto slot, [31:7] zero.

Function
REQ-017 FSM states IDLE, ISSUE, MOVING, SETTLE; one transition per clk maximum.
REQ-018 Two single-entry mailboxes (cpu, auto); a new strobe overwrites that mailbox's pending value and sets its pending flag, in any state.
REQ-019 Auto target = auto_slot * STEPS_PER_SLOT, computed as unsigned 32-bit.
REQ-020 IDLE: if cpu pending, select cpu; else if auto pending, select auto; selected pending flag clears and FSM moves to ISSUE next cycle.
REQ-021 Strobe in same cycle as its pending flag clears: new value kept, flag stays set.
REQ-022 Selected target equal to cur_pos: no command issued, FSM stays IDLE, pending flag still cleared.
REQ-023 ISSUE: step_valid=1, step_target held stable until step_valid && step_ready; on handshake cur_pos <= step_target, go MOVING.
REQ-024 MOVING: wait for step_busy high then low (first falling edge after handshake); step_busy already low for 2 cycles after handshake counts as done; then go SETTLE.
REQ-025 SETTLE: count SETTLE_CYCLES then return IDLE; SETTLE_CYCLES=0 returns next cycle.
REQ-026 Simultaneous cpu_valid and auto_valid: both captured; cpu served first.
REQ-027 Requests arriving during ISSUE/MOVING/SETTLE never abort the current move.
REQ-028 step_valid is only asserted in ISSUE; never dropped before handshake.

Reset
REQ-029 reset_n low at clk edge: FSM IDLE, step_valid 0, step_target 0, cur_pos 0, pending flags 0, fault 0, counters 0, status 0.
REQ-030 Reset mid-move abandons the move with no further command; cur_pos returns to 0 (stepper is re-homed externally).

Configuration
REQ-031 Macro GOALIE_TIMEOUT_EN defined: watchdog counts cycles in ISSUE+MOVING; reaching TIMEOUT_CYCLES forces IDLE, drops step_valid, sets fault (sticky until reset); fault blocks auto requests, cpu requests still served and do not clear fault.
REQ-032 Macro undefined: no watchdog logic; status[3] tied 0; FSM waits indefinitely.

Verification
REQ-033 auto_valid, slot=3, step_ready=1, busy pulse 10 cycles -> step_target=600, cur_pos=600, busy low after SETTLE_CYCLES.
REQ-034 cpu_valid target=1234 and auto_valid slot=5 same cycle -> commands 1234 then 1000, in order.
REQ-035 Three auto strobes (slots 1,2,7) during MOVING -> only 1400 issued afterwards.
REQ-036 step_ready low 50 cycles in ISSUE -> step_valid high and step_target constant for all 50 cycles.
REQ-037 cur_pos=600, auto slot=3 -> no step_valid, stays IDLE, auto_pending cleared.
REQ-038 GOALIE_TIMEOUT_EN, TIMEOUT_CYCLES=100, step_busy stuck high -> IDLE at cycle 100, status[3]=1; subsequent auto ignored, cpu served.

Source files
------------

// File: rtl/goalie_move_ctrl.sv
// Goalie positioning controller: arbitrates CPU and scanner targets and drives a stepper handshake.
// Optional move watchdog enabled by defining GOALIE_TIMEOUT_EN.
module goalie_move_ctrl #(
  parameter int unsigned STEPS_PER_SLOT = 200,
  parameter int unsigned SETTLE_CYCLES  = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        auto_valid,
  input  logic [2:0]  auto_slot,
  input  logic        cpu_valid,
  input  logic [31:0] cpu_target,
  output logic        step_valid,
  input  logic        step_ready,
  output logic [31:0] step_target,
  input  logic        step_busy,
  output logic        busy,
  output logic [31:0] cur_pos,
  output logic [31:0] status,
  output logic [1:0]  state_dbg
);

  // Stepper handshake: a command transfers on a clk edge where step_valid && step_ready;
  // step_valid and step_target stay stable from assertion until that edge.

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] MOVING = 2'd2;
  localparam logic [1:0] SETTLE = 2'd3;

  localparam logic [31:0] STEPS_W  = 32'(STEPS_PER_SLOT);
  localparam logic [32:0] SETTLE_W = 33'(SETTLE_CYCLES);

  logic [1:0]  state_q, state_d;
  logic        cpu_pend_q, cpu_pend_d;
  logic [31:0] cpu_tgt_q, cpu_tgt_d;
  logic        auto_pend_q, auto_pend_d;
  logic [2:0]  auto_slot_q, auto_slot_d;
  logic [31:0] step_target_q, step_target_d;
  logic [31:0] cur_pos_q, cur_pos_d;
  logic [31:0] settle_cnt_q, settle_cnt_d;
  logic        seen_busy_q, seen_busy_d;
  logic        low_cnt_q, low_cnt_d;
  logic        fault;

  logic [31:0] auto_tgt;
  logic [31:0] sel_tgt;
  logic        take;
  logic        cpu_clr;
  logic        auto_clr;
  logic        settle_done;

  assign auto_tgt    = 32'(auto_slot_q) * STEPS_W;
  assign settle_done = ({1'b0, settle_cnt_q} + 33'd1) >= SETTLE_W;

`ifdef GOALIE_TIMEOUT_EN
  localparam logic [32:0] TIMEOUT_W = 33'(TIMEOUT_CYCLES);
  logic        fault_q, fault_d;
  logic [31:0] wd_cnt_q, wd_cnt_d;
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    step_target_d = step_target_q;
    cur_pos_d     = cur_pos_q;
    settle_cnt_d  = settle_cnt_q;
    seen_busy_d   = seen_busy_q;
    low_cnt_d     = low_cnt_q;
    cpu_tgt_d     = cpu_valid ? cpu_target : cpu_tgt_q;
    auto_slot_d   = auto_valid ? auto_slot : auto_slot_q;
    sel_tgt       = cpu_tgt_q;
    take          = 1'b0;
    cpu_clr       = 1'b0;
    auto_clr      = 1'b0;
`ifdef GOALIE_TIMEOUT_EN
    fault_d       = fault_q;
    wd_cnt_d      = wd_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (cpu_pend_q) begin
          cpu_clr = 1'b1;
          sel_tgt = cpu_tgt_q;
          take    = 1'b1;
        end else if (auto_pend_q && !fault) begin
          auto_clr = 1'b1;
          sel_tgt  = auto_tgt;
          take     = 1'b1;
        end
        // A target equal to the committed position is consumed without a move.
        if (take && (sel_tgt != cur_pos_q)) begin
          step_target_d = sel_tgt;
          state_d       = ISSUE;
`ifdef GOALIE_TIMEOUT_EN
          wd_cnt_d      = '0;
`endif
        end
      end
      ISSUE: begin
        if (step_ready) begin
          cur_pos_d   = step_target_q;
          seen_busy_d = 1'b0;
          low_cnt_d   = 1'b0;
          state_d     = MOVING;
        end
      end
      MOVING: begin
        // Done on the first busy fall, or if busy never rose within two cycles.
        if (step_busy) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy_q || low_cnt_q) begin
          settle_cnt_d = '0;
          state_d      = SETTLE;
        end else begin
          low_cnt_d = 1'b1;
        end
      end
      default: begin
        if (settle_done) begin
          settle_cnt_d = '0;
          state_d      = IDLE;
        end else begin
          settle_cnt_d = settle_cnt_q + 32'd1;
        end
      end
    endcase

`ifdef GOALIE_TIMEOUT_EN
    if (state_q == ISSUE || state_q == MOVING) begin
      if (({1'b0, wd_cnt_q} + 33'd1) >= TIMEOUT_W) begin
        state_d  = IDLE;
        fault_d  = 1'b1;
        wd_cnt_d = '0;
      end else begin
        wd_cnt_d = wd_cnt_q + 32'd1;
      end
    end
`endif

    // A strobe coinciding with its flag being consumed wins.
    cpu_pend_d  = cpu_valid ? 1'b1 : (cpu_clr ? 1'b0 : cpu_pend_q);
    auto_pend_d = (auto_valid && !fault) ? 1'b1 : (auto_clr ? 1'b0 : auto_pend_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cpu_pend_q    <= 1'b0;
      cpu_tgt_q     <= '0;
      auto_pend_q   <= 1'b0;
      auto_slot_q   <= '0;
      step_target_q <= '0;
      cur_pos_q     <= '0;
      settle_cnt_q  <= '0;
      seen_busy_q   <= 1'b0;
      low_cnt_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cpu_pend_q    <= cpu_pend_d;
      cpu_tgt_q     <= cpu_tgt_d;
      auto_pend_q   <= auto_pend_d;
      auto_slot_q   <= auto_slot_d;
      step_target_q <= step_target_d;
      cur_pos_q     <= cur_pos_d;
      settle_cnt_q  <= settle_cnt_d;
      seen_busy_q   <= seen_busy_d;
      low_cnt_q     <= low_cnt_d;
    end
  end

`ifdef GOALIE_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fault_q  <= 1'b0;
      wd_cnt_q <= '0;
    end else begin
      fault_q  <= fault_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end
`endif

  assign step_valid  = (state_q == ISSUE);
  assign step_target = step_target_q;
  assign busy        = (state_q != IDLE);
  assign cur_pos     = cur_pos_q;
  assign status      = {25'd0, auto_slot_q, fault, auto_pend_q, cpu_pend_q, busy};
  assign state_dbg   = state_q;

endmodule
